// File: rtl/hdmi_pll_pkg.sv
// ============================================================================
// Module : hdmi_pll_pkg
// Brief  : Shared state encoding and default settings for the HDMI PLL supervisor.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hdmi_pll_pkg;

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STABLE = 3'd2,
        ST_LOCKED = 3'd3,
        ST_FAIL   = 3'd4
    } state_t;

    localparam logic [5:0] C_ICPSEL_INIT  = 6'd16;
    localparam logic [2:0] C_LPFRES_START = 3'd0;

endpackage

`default_nettype wire

// File: rtl/sync2.sv
// ============================================================================
// Module : sync2
// Brief  : Generic two-flop single-bit synchronizer, resets to 0.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/hdmi_pll_seq.sv
// ============================================================================
// Module : hdmi_pll_seq
// Brief  : HDMI PLL reset/lock supervisor with timeout, debounce and lpfres sweep.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hdmi_pll_seq
    import hdmi_pll_pkg::*;
#(
    parameter int         RST_CYC          = 16,
    parameter int         LOCK_TIMEOUT_CYC = 50000,
    parameter int         STABLE_CYC       = 1024,
    parameter int         MAX_TRY          = 8,
    parameter logic [5:0] ICPSEL_INIT      = C_ICPSEL_INIT,
    parameter logic [2:0] LPFRES_START     = C_LPFRES_START
) (
    input  logic       init_clk,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       force_relock,
    output logic       pll_rst,
    output logic [5:0] icpsel,
    output logic [2:0] lpfres,
    output logic       video_rst,
    output logic       locked,
    output logic       fail,
    output logic [3:0] try_cnt
);

    localparam int c_MAX_A   = (RST_CYC > LOCK_TIMEOUT_CYC) ? RST_CYC : LOCK_TIMEOUT_CYC;
    localparam int c_MAX_CYC = (c_MAX_A > STABLE_CYC) ? c_MAX_A : STABLE_CYC;
    localparam int c_TW      = $clog2(c_MAX_CYC) + 1;

    localparam logic [c_TW-1:0] c_RST_END    = c_TW'(RST_CYC - 1);
    localparam logic [c_TW-1:0] c_WAIT_END   = c_TW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [c_TW-1:0] c_STABLE_END = c_TW'(STABLE_CYC - 1);
    localparam logic [3:0]      c_MAX_TRY    = 4'(MAX_TRY);

    state_t          r_state;
    logic [c_TW-1:0] r_timer;
    logic [3:0]      r_try_cnt;
    logic [2:0]      r_lpfres;
    logic            r_pll_rst;
    logic            r_video_rst;
    logic            r_locked;
    logic            r_fail;
    logic            w_lock_s;

    state_t          w_state_nxt;
    logic [c_TW-1:0] w_timer_nxt;
    logic [3:0]      w_try_nxt;
    logic [2:0]      w_lpf_nxt;

    sync2 u_lock_sync (
        .clk (init_clk),
        .rst (reset),
        .d   (pll_lock),
        .q   (w_lock_s)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer + 1'b1;
        w_try_nxt   = r_try_cnt;
        w_lpf_nxt   = r_lpfres;

        case (r_state)
            ST_RST: begin
                if (r_timer == c_RST_END) begin
                    w_state_nxt = ST_WAIT;
                    if (r_try_cnt < c_MAX_TRY) begin
                        w_try_nxt = r_try_cnt + 4'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (w_lock_s) begin
                    w_state_nxt = ST_STABLE;
                end else if (r_timer == c_WAIT_END) begin
                    if (r_try_cnt == c_MAX_TRY) begin
                        w_state_nxt = ST_FAIL;
                    end else begin
                        w_state_nxt = ST_RST;
                        w_lpf_nxt   = r_lpfres + 3'd1;
                    end
                end
            end
            ST_STABLE: begin
                // A lock drop sends us back to WAIT without costing an attempt.
                if (!w_lock_s) begin
                    w_state_nxt = ST_WAIT;
                end else if (r_timer == c_STABLE_END) begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                w_timer_nxt = '0;
                // Keep lpfres on lock loss: it already produced a lock.
                if (!w_lock_s) begin
                    w_state_nxt = ST_RST;
                    w_try_nxt   = 4'd0;
                end
            end
            ST_FAIL: begin
                w_timer_nxt = '0;
            end
            default: begin
                w_state_nxt = ST_RST;
                w_timer_nxt = '0;
            end
        endcase

        if (w_state_nxt != r_state) begin
            w_timer_nxt = '0;
        end

        if (force_relock) begin
            w_state_nxt = ST_RST;
            w_timer_nxt = '0;
            w_try_nxt   = 4'd0;
            w_lpf_nxt   = LPFRES_START;
        end
    end

    // Output flops decode the next state so they switch together with r_state.
    always_ff @(posedge init_clk) begin
        if (reset) begin
            r_state     <= ST_RST;
            r_timer     <= '0;
            r_try_cnt   <= 4'd0;
            r_lpfres    <= LPFRES_START;
            r_pll_rst   <= 1'b1;
            r_video_rst <= 1'b1;
            r_locked    <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_try_cnt   <= w_try_nxt;
            r_lpfres    <= w_lpf_nxt;
            r_pll_rst   <= (w_state_nxt == ST_RST) || (w_state_nxt == ST_FAIL);
            r_video_rst <= (w_state_nxt != ST_LOCKED);
            r_locked    <= (w_state_nxt == ST_LOCKED);
            r_fail      <= (w_state_nxt == ST_FAIL);
        end
    end

    assign pll_rst   = r_pll_rst;
    assign icpsel    = ICPSEL_INIT;
    assign lpfres    = r_lpfres;
    assign video_rst = r_video_rst;
    assign locked    = r_locked;
    assign fail      = r_fail;
    assign try_cnt   = r_try_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hdmi_pll_seq.sv
// ============================================================================
// Module : tb_hdmi_pll_seq
// Brief  : Directed self-checking bench for the HDMI PLL supervisor.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hdmi_pll_seq;

    localparam int RC = 4;
    localparam int TO = 20;
    localparam int SC = 8;
    localparam int MT = 3;
    localparam int NS = 100;

    logic       init_clk = 1'b0;
    logic       reset = 1'b1;
    logic       pll_lock = 1'b0;
    logic       force_relock = 1'b0;
    logic       pll_rst;
    logic [5:0] icpsel;
    logic [2:0] lpfres;
    logic       video_rst;
    logic       locked;
    logic       fail;
    logic [3:0] try_cnt;

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        int n, rst, lk, frc, prst, vrst, lck, fl, tr, lpf;
    } vec_t;

    vec_t tbl[14];

    int   s_prst[NS];
    int   s_fail[NS];
    int   s_lpf[NS];
    int   s_try[NS];
    int   falls[$];
    int   rises[$];

    hdmi_pll_seq #(
        .RST_CYC          (RC),
        .LOCK_TIMEOUT_CYC (TO),
        .STABLE_CYC       (SC),
        .MAX_TRY          (MT)
    ) dut (
        .init_clk     (init_clk),
        .reset        (reset),
        .pll_lock     (pll_lock),
        .force_relock (force_relock),
        .pll_rst      (pll_rst),
        .icpsel       (icpsel),
        .lpfres       (lpfres),
        .video_rst    (video_rst),
        .locked       (locked),
        .fail         (fail),
        .try_cnt      (try_cnt)
    );

    always #5 init_clk = ~init_clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge init_clk);
        #1;
    endtask

    task automatic wait_level(input logic lvl, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (pll_rst == lvl) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        force_relock = 1'b0;
        pll_lock = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int cnt;

        //           n  rst lk frc prst vrst lck fl tr lpf
        tbl[0]  = '{ 2, 1, 0, 0, 1, 1, 0, 0, 0, 0};
        tbl[1]  = '{ 3, 0, 0, 0, 1, 1, 0, 0, 0, 0};
        tbl[2]  = '{ 1, 0, 0, 0, 0, 1, 0, 0, 1, 0};
        tbl[3]  = '{ 5, 0, 0, 0, 0, 1, 0, 0, 1, 0};
        tbl[4]  = '{10, 0, 1, 0, 0, 1, 0, 0, 1, 0};
        tbl[5]  = '{ 1, 0, 1, 0, 0, 0, 1, 0, 1, 0};
        tbl[6]  = '{ 2, 0, 0, 0, 0, 0, 1, 0, 1, 0};
        tbl[7]  = '{ 1, 0, 0, 0, 1, 1, 0, 0, 0, 0};
        tbl[8]  = '{ 3, 0, 0, 0, 1, 1, 0, 0, 0, 0};
        tbl[9]  = '{ 1, 0, 0, 0, 0, 1, 0, 0, 1, 0};
        tbl[10] = '{ 3, 0, 0, 0, 0, 1, 0, 0, 1, 0};
        tbl[11] = '{ 1, 0, 0, 1, 1, 1, 0, 0, 0, 0};
        tbl[12] = '{ 2, 0, 0, 0, 1, 1, 0, 0, 0, 0};
        tbl[13] = '{ 1, 1, 0, 1, 1, 1, 0, 0, 0, 0};

        // Normal lock, lock loss, force_relock mid-WAIT, reset+force together
        for (int v = 0; v < 14; v++) begin
            reset        = (tbl[v].rst != 0);
            pll_lock     = (tbl[v].lk != 0);
            force_relock = (tbl[v].frc != 0);
            for (int c = 0; c < tbl[v].n; c++) begin
                tick();
                chk($sformatf("v%0d.%0d pll_rst", v, c), int'(pll_rst), tbl[v].prst);
                chk($sformatf("v%0d.%0d video_rst", v, c), int'(video_rst), tbl[v].vrst);
                chk($sformatf("v%0d.%0d locked", v, c), int'(locked), tbl[v].lck);
                chk($sformatf("v%0d.%0d fail", v, c), int'(fail), tbl[v].fl);
                chk($sformatf("v%0d.%0d try_cnt", v, c), int'(try_cnt), tbl[v].tr);
                chk($sformatf("v%0d.%0d lpfres", v, c), int'(lpfres), tbl[v].lpf);
            end
        end
        chk("icpsel", int'(icpsel), 16);

        // Timeout sweep: record outputs and analyse pll_rst edges
        do_reset();
        for (int i = 0; i < NS; i++) begin
            tick();
            s_prst[i] = int'(pll_rst);
            s_fail[i] = int'(fail);
            s_lpf[i]  = int'(lpfres);
            s_try[i]  = int'(try_cnt);
        end
        for (int i = 1; i < NS; i++) begin
            if (s_prst[i-1] == 1 && s_prst[i] == 0) falls.push_back(i);
            if (s_prst[i-1] == 0 && s_prst[i] == 1) rises.push_back(i);
        end
        chk("sweep_falls", falls.size(), 3);
        chk("sweep_rises", rises.size(), 3);
        for (int k = 0; k < falls.size() && k < 3; k++) begin
            chk($sformatf("sweep_lpf%0d", k), s_lpf[falls[k]], k);
            chk($sformatf("sweep_try%0d", k), s_try[falls[k]], k + 1);
            if (k < rises.size())
                chk($sformatf("sweep_wait_len%0d", k), rises[k] - falls[k], TO);
            if (k >= 1 && k - 1 < rises.size())
                chk($sformatf("sweep_rst_len%0d", k), falls[k] - rises[k-1], RC);
        end
        if (rises.size() == 3) begin
            chk("sweep_fail_at_last_rise", s_fail[rises[2]], 1);
            chk("sweep_no_fail_before", s_fail[rises[2]-1], 0);
        end
        chk("sweep_end_prst", s_prst[NS-1], 1);
        chk("sweep_end_fail", s_fail[NS-1], 1);
        chk("sweep_end_try", s_try[NS-1], MT);
        chk("sweep_end_lpf", s_lpf[NS-1], 2);

        // force_relock out of FAIL
        force_relock = 1'b1;
        tick();
        force_relock = 1'b0;
        chk("frc_fail fail", int'(fail), 0);
        chk("frc_fail pll_rst", int'(pll_rst), 1);
        chk("frc_fail lpfres", int'(lpfres), 0);
        chk("frc_fail try_cnt", int'(try_cnt), 0);

        // Stability glitch: one-cycle lock drop during STABLE
        wait_level(1'b0, ok);
        chk("glitch_wait_fall", int'(ok), 1);
        repeat (5) tick();
        pll_lock = 1'b1;
        repeat (3) tick();
        chk("glitch_pre_drop locked", int'(locked), 0);
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        cnt = 9;
        for (int i = 0; i < 40 && !locked; i++) begin
            tick();
            cnt++;
        end
        chk("glitch_lock_latency", cnt, 20);
        chk("glitch try_cnt", int'(try_cnt), 1);
        chk("glitch lpfres", int'(lpfres), 0);

        // Lock loss on second attempt keeps lpfres=1
        do_reset();
        wait_level(1'b0, ok);
        chk("loss_fall1", int'(ok), 1);
        wait_level(1'b1, ok);
        chk("loss_rise1", int'(ok), 1);
        wait_level(1'b0, ok);
        chk("loss_fall2", int'(ok), 1);
        chk("loss_attempt lpfres", int'(lpfres), 1);
        chk("loss_attempt try_cnt", int'(try_cnt), 2);
        repeat (5) tick();
        pll_lock = 1'b1;
        repeat (10) tick();
        chk("loss_pre locked", int'(locked), 0);
        tick();
        chk("loss locked", int'(locked), 1);
        chk("loss video_rst", int'(video_rst), 0);
        pll_lock = 1'b0;
        tick();
        tick();
        chk("loss_hold locked", int'(locked), 1);
        tick();
        chk("loss_drop locked", int'(locked), 0);
        chk("loss_drop video_rst", int'(video_rst), 1);
        chk("loss_drop pll_rst", int'(pll_rst), 1);
        chk("loss_drop lpfres", int'(lpfres), 1);
        chk("loss_drop try_cnt", int'(try_cnt), 0);
        repeat (RC) tick();
        chk("loss_retry pll_rst", int'(pll_rst), 0);
        chk("loss_retry try_cnt", int'(try_cnt), 1);
        chk("loss_retry lpfres", int'(lpfres), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hdmi_pll_seq.md
Name: hdmi_pll_seq

Overview:
- Supervises the HDMI pixel-clock PLL from the always-running init clock.
- Sequences PLL reset, waits for lock with a timeout, debounces lock, and sweeps loop-filter resistance across retries.
- Holds the downstream video reset until the clock is stable, and re-runs the sequence when lock is lost or a relock is requested.
- Sits beside hdmi_pll, replacing fixed calibration settings with a supervised sequence.

Parameters:
- RST_CYC, 16: cycles pll_rst is held high per attempt (≥1).
- LOCK_TIMEOUT_CYC, 50000: cycles to wait for first lock per attempt (1 ms at 20 ns).
- STABLE_CYC, 1024: consecutive synced-lock cycles required before declaring locked.
- MAX_TRY, 8: attempts before FAIL (1..8); one lpfres value per attempt.
- ICPSEL_INIT, 6'd16: charge-pump setting driven on icpsel, constant.
- LPFRES_START, 3'd0: lpfres value for the first attempt.

Ports:
- init_clk, in, 1: controller clock.
- reset, in, 1: synchronous active-high reset.
- pll_lock, in, 1: raw PLL lock, asynchronous to init_clk.
- force_relock, in, 1: single-cycle request to restart the sequence.
- pll_rst, out, 1: PLL reset.
- icpsel, out, 6: charge-pump current select.
- lpfres, out, 3: loop-filter resistor select.
- video_rst, out, 1: downstream reset; high unless the state is LOCKED.
- locked, out, 1: clock good.
- fail, out, 1: all attempts exhausted.
- try_cnt, out, 4: attempts started, saturating at MAX_TRY.

Behaviour:
- Interface: one clock, init_clk; reset is synchronous and active-high, port name reset.
- pll_lock passes through a 2-flop synchronizer (lock_s). All logic uses lock_s, so lock is seen 2 cycles late.
- Reset values:
  - pll_rst=1, video_rst=1, locked=0, fail=0, try_cnt=0.
  - lpfres=LPFRES_START, icpsel=ICPSEL_INIT.
  - state=RST, timer=0, synchronizer flops=0.
- States and transitions:
  - RST: pll_rst=1. timer counts to RST_CYC-1, then go to WAIT, clear timer, increment try_cnt.
  - WAIT: pll_rst=0.
    - If lock_s=1: go to STABLE, timer=0.
    - Else if timer=LOCK_TIMEOUT_CYC-1: this is a timeout.
      - If try_cnt=MAX_TRY: go to FAIL.
      - Otherwise lpfres <= lpfres+1 (wraps modulo 8) and go to RST.
  - STABLE: if lock_s=0, go back to WAIT with timer=0. This does not count as an attempt, and the timeout restarts. When timer reaches STABLE_CYC-1 with lock_s=1, go to LOCKED.
  - LOCKED: locked=1, video_rst=0.
    - lock_s=0 (lock loss): go to RST. Clear try_cnt to 0 and keep the current lpfres, which is known good.
  - FAIL: pll_rst=1, fail=1, video_rst=1. Sticky until reset or force_relock.
- Outputs are registered. locked and video_rst change in the same cycle the state enters or leaves LOCKED.
- force_relock:
  - In any state, go to RST next cycle, with timer=0, try_cnt=0, fail=0 and lpfres=LPFRES_START.
  - It has priority over every other transition.
  - Asserted together with reset: reset wins, with identical result.
- Timer width is clog2 of the maximum of (RST_CYC, LOCK_TIMEOUT_CYC, STABLE_CYC), plus 1. Timer clears on every state change.
- pll_rst is glitch-free: driven from a registered state decode.
- Reset mid-sequence returns everything to reset values next cycle. There is no partial state.

Decomposition:
- Package hdmi_pll_pkg:
  - state enum (RST, WAIT, STABLE, LOCKED, FAIL), 3-bit encoding.
  - Default constants for ICPSEL_INIT and LPFRES_START.
- One sub-module: sync2, a generic 2-flop bit synchronizer with reset value 0. It is reusable for other CDC inputs.
- The FSM, timer and lpfres sweep stay in hdmi_pll_seq.

Test Plan:
- Bench uses RST_CYC=4, LOCK_TIMEOUT_CYC=20, STABLE_CYC=8, MAX_TRY=3, and sets pll_lock 5 cycles after pll_rst falls.
- Normal lock:
  - pll_rst high for exactly 4 cycles.
  - locked=1 and video_rst=0 exactly 5+2+8(+1 transition) cycles after pll_rst falls.
  - try_cnt=1, lpfres=0.
- Timeout sweep: pll_lock tied 0 → three pll_rst pulses with lpfres 0,1,2. fail=1 after the third 20-cycle WAIT; try_cnt=3; pll_rst stays 1.
- Stability glitch: lock rises, drops for 1 cycle during STABLE, then stays up → back to WAIT and then STABLE. locked only after 8 uninterrupted cycles; try_cnt unchanged at 1.
- Lock loss: from LOCKED, drop pll_lock.
  - video_rst=1 and locked=0 three cycles later (2 sync + 1).
  - New RST pulse with the same lpfres; try_cnt goes to 1.
- force_relock in FAIL and mid-WAIT: next cycle state=RST, fail=0, lpfres=0, try_cnt=0. Together with reset: all outputs equal reset values.
